// File: rtl/cpu_oci_dct_trace_monitor.sv
// DCT trace capture FIFO with end-of-test sequencing (RUN/DRAIN/DONE) and a FWFT read port.
// Optional macro DCT_TIMESTAMP_EN appends a 16-bit cycle timestamp to each stored entry.
module cpu_oci_dct_trace_monitor #(
    parameter int DATA_W  = 30,
    parameter int COUNT_W = 4,
    parameter int DEPTH   = 16,
    parameter int OVF_W   = 8,
    localparam int AW     = $clog2(DEPTH),
`ifdef DCT_TIMESTAMP_EN
    localparam int TS_W   = 16,
`else
    localparam int TS_W   = 0,
`endif
    localparam int ENTRY_W = COUNT_W + DATA_W + TS_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  dct_buffer,
    input  logic [COUNT_W-1:0] dct_count,
    input  logic               dct_valid,
    input  logic               test_ending,
    input  logic               test_has_ended,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [AW:0]        fill_level,
    output logic               overflow,
    output logic [OVF_W-1:0]   overflow_count,
    output logic [1:0]         state,
    output logic               done
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             state_reg, state_next;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]        fill_reg, fill_after;
    logic [OVF_W-1:0]   ovf_cnt_reg;
    logic               ovf_reg, ended_reg, done_reg, done_next;
    logic               pop, push, drop, full;
    logic [ENTRY_W-1:0] wr_entry;

    assign rd_valid = (fill_reg != '0);
    assign full     = (fill_reg == (AW+1)'(DEPTH));
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
    assign push     = dct_valid && (state_reg == RUN) && (!full || pop);
    assign drop     = dct_valid && (state_reg == RUN) && full && !pop;
    assign fill_after = fill_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

`ifdef DCT_TIMESTAMP_EN
    logic [15:0] ts_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_reg <= '0;
        else       ts_reg <= ts_reg + 16'd1;
    end

    assign wr_entry = {dct_count, dct_buffer, ts_reg};
`else
    assign wr_entry = {dct_count, dct_buffer};
`endif

    // Storage is never reset; rd_data is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= wr_entry;
    end

    assign rd_data = rd_valid ? mem[rd_ptr_reg] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            fill_reg    <= '0;
            ovf_reg     <= 1'b0;
            ovf_cnt_reg <= '0;
            ended_reg   <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            fill_reg <= fill_after;
            if (drop) begin
                ovf_reg <= 1'b1;
                if (ovf_cnt_reg != '1) ovf_cnt_reg <= ovf_cnt_reg + OVF_W'(1);
            end
            if (test_has_ended) ended_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    // test_has_ended takes priority over test_ending when both arrive together.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN: begin
                if (test_has_ended)   state_next = (fill_after == '0) ? DONE : DRAIN;
                else if (test_ending) state_next = DRAIN;
            end
            DRAIN: begin
                if ((ended_reg || test_has_ended) && fill_after == '0) state_next = DONE;
            end
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        done_next = (state_next == DONE);
    end

    assign state          = state_reg;
    assign done           = done_reg;
    assign fill_level     = fill_reg;
    assign overflow       = ovf_reg;
    assign overflow_count = ovf_cnt_reg;

endmodule

// File: doc/cpu_oci_dct_trace_monitor.md
Name: cpu_oci_dct_trace_monitor

Overview:
Parametrised successor to the CPU OCI test-bench hook. It captures data-capture-trace (DCT) frames from the CPU OCI into an on-chip FIFO of configurable width and depth. It sequences end-of-test (ending, draining, done) and exposes the frames on a first-word-fall-through ready/valid read port. It sits beside the CPU OCI and feeds a simulation checker or an on-chip debug readout.

Parameters:
DATA_W, 30, width of dct_buffer.
COUNT_W, 4, width of dct_count.
DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
OVF_W, 8, width of the saturating overflow counter.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous active-high reset
dct_buffer  in  DATA_W  trace payload
dct_count  in  COUNT_W  trace fill count accompanying payload
dct_valid  in  1  frame strobe; one frame per cycle while high
test_ending  in  1  stop accepting new frames
test_has_ended  in  1  test finished; complete after drain
rd_ready  in  1  consumer accepts head entry
rd_valid  out  1  head entry present (FIFO not empty)
rd_data  out  ENTRY_W  head entry {dct_count, dct_buffer} (MSB = count); ENTRY_W = COUNT_W+DATA_W (+16 with option)
fill_level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: at least one frame dropped
overflow_count  out  OVF_W  dropped frames, saturating at all-ones
state  out  2  00 RUN, 01 DRAIN, 10 DONE
done  out  1  high in DONE

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values: state=RUN, FIFO empty, rd_valid=0, rd_data=0, fill_level=0, overflow=0, overflow_count=0, done=0.
- FWFT read port:
  - rd_valid = (fill_level != 0); rd_data = head entry, combinational from the registered RAM/pointer.
  - Pop occurs on rd_valid && rd_ready at the clock edge.
  - rd_ready while rd_valid=0 has no effect.
- Push condition: dct_valid && state==RUN && (fill_level<DEPTH || pop this cycle).
  - A push is visible on rd_valid the next cycle. Write-to-read latency is 1 cycle.
- Push into an empty FIFO: no same-cycle bypass; rd_valid rises 1 cycle after the push edge.
- Simultaneous push and pop: fill_level unchanged; at full this is legal and no drop occurs.
- Drop condition: dct_valid && state==RUN && full && no pop.
  - Frame discarded, overflow<=1, overflow_count increments and saturates (no wrap).
- Frames offered in DRAIN or DONE: ignored silently; not counted as overflow.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Full/empty is distinguished by fill_level, not by pointer equality.
- FSM:
  - RUN -> DRAIN when test_ending=1.
  - RUN -> DONE when test_has_ended=1 and FIFO is empty after this cycle's pop, with no push this cycle. If not empty, go to DRAIN.
  - DRAIN -> DONE when test_has_ended=1 (or was seen earlier; latched in an internal ended flag) and fill_level==0 after this cycle's pop.
  - DONE is absorbing until reset. In DONE, pops are still accepted, but the FIFO is empty.
  - test_ending and test_has_ended in the same cycle: treated as test_has_ended (DRAIN, or DONE if empty).
- done is registered: it equals (state==DONE) and asserts the cycle after the transition edge.
- Reset mid-operation: the FIFO is emptied immediately (asynchronous). RAM contents need not be cleared, but rd_data must read 0 while rd_valid=0.

Optional Feature:
DCT_TIMESTAMP_EN
- Defined:
  - A 16-bit free-running cycle counter is added. It resets to 0, increments every cycle, and wraps 0xFFFF->0x0000.
  - Each pushed entry appends the counter value sampled on the push edge as the LSBs: rd_data = {dct_count, dct_buffer, ts[15:0]}, ENTRY_W = COUNT_W+DATA_W+16.
- Undefined: no counter; ENTRY_W = COUNT_W+DATA_W; no timestamp logic is synthesised.

Test Plan:
- Reset, then push dct_buffer=0x1234567, dct_count=3 with rd_ready=0 -> next cycle rd_valid=1, rd_data={4'h3,30'h1234567}, fill_level=1.
- Push 17 frames into DEPTH=16 with rd_ready=0 -> fill_level=16, overflow=1, overflow_count=1; reading back returns frames 0..15 in order.
- At full, push and pop in the same cycle for 20 cycles -> fill_level stays 16, overflow_count unchanged, FIFO order preserved.
- 300 drops with OVF_W=8 -> overflow_count=255 and holds.
- 4 entries queued, test_ending=1, then dct_valid frames offered, then test_has_ended pulse for 1 cycle, then drain with rd_ready=1 -> state=DRAIN, extra frames absent, overflow_count=0; done=1 one cycle after the 4th pop.
- Reset asserted while fill_level=5 and state=DRAIN -> immediately rd_valid=0, fill_level=0, state=RUN. With DCT_TIMESTAMP_EN, the first push 10 cycles after reset release carries ts=10.
